// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq_if.sv
// Execute-stage <-> divider handshake and operand/result bus.
interface div_seq_if #(
  parameter int unsigned WIDTH = muldiv_pkg::WIDTH_DEF
) ();

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cancel_i;
  logic             stall_o;
  logic             valid_o;
  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;

  modport master (
    output start_i, signed_i, a_i, b_i, cancel_i,
    input  stall_o, valid_o, quot_o, rem_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, cancel_i,
    output stall_o, valid_o, quot_o, rem_o
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit,
// subtract the divisor if it fits, and emit the quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub;

  assign shifted = {rem_i, bit_i};
  // When the divisor fits the difference is below 2^WIDTH, so modular subtract is exact.
  assign sub     = shifted[WIDTH-1:0] - div_i;
  assign q_o     = (shifted >= {1'b0, div_i});
  assign rem_o   = q_o ? sub : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential DIV/DIVU unit: WIDTH restoring iterations on magnitudes,
// then one cycle of sign fix-up and a one-cycle result pulse.
module div_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  io
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign a_mag = (io.signed_i && io.a_i[WIDTH-1]) ? -io.a_i : io.a_i;
  assign b_mag = (io.signed_i && io.b_i[WIDTH-1]) ? -io.b_i : io.b_i;

  // quo_q doubles as the dividend shift register: dividend bits leave at the top,
  // quotient bits enter at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[WIDTH-1]),
    .div_i (div_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.start_i) begin
          state_d = BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          div_d   = b_mag;
          qneg_d  = io.signed_i & (io.a_i[WIDTH-1] ^ io.b_i[WIDTH-1]);
          rneg_d  = io.signed_i & io.a_i[WIDTH-1];
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = SIGN;
          cnt_d   = '0;
        end
      end
      SIGN: begin
        quot_d  = qneg_q ? -quo_q : quo_q;
        remo_d  = rneg_q ? -rem_q : rem_q;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush overrides everything, including a same-cycle start.
    if (io.cancel_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      quot_d  = quot_q;
      remo_d  = remo_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      valid_q <= valid_d;
    end
  end

  // Stall drops in DONE so the instruction retires together with its result.
  assign io.stall_o = rst & ((state_q == IDLE && io.start_i && !io.cancel_i) ||
                             state_q == BUSY || state_q == SIGN);
  assign io.valid_o = valid_q;
  assign io.quot_o  = quot_q;
  assign io.rem_o   = remo_q;

endmodule
